hazard_unit: RTL
================

# hazard_unit

Decode-stage pipeline control for the 16-bit five-stage core. It sits directly upstream of `id_ex` and drives that register's write enable and bubble/flush input, plus the PC and `if_id` enables. It keeps its own three-slot destination scoreboard covering the EX, MEM and WB stages, and from it:
- inserts load-use or read-after-write stall bubbles;
- squashes wrong-path instructions on EX-stage redirects;
- sequences pipeline drain on HALT.

## Interface
Parameters:
- `FORWARD`, default 1: 1 means EX/MEM forwarding exists, so only load-use stalls; 0 means no forwarding, so stall until the writer leaves WB.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge only.
- `id_valid`  in  1  ID holds a real instruction.
- `id_Read1`, `id_Read2`  in  1 each  ID instruction reads `id_R_reg1` / `id_R_reg2`.
- `id_R_reg1`, `id_R_reg2`  in  3 each  source register indices.
- `id_wreg_flag`  in  1  ID instruction writes a register.
- `id_reg_to_write`  in  3  destination index.
- `id_MemRead`  in  1  ID instruction is a load.
- `id_halt`  in  1  ID instruction is HALT.
- `ex_redirect`  in  1  EX resolved a taken branch/JR/jump this cycle.
- `pc_w_en`  out  1  PC update enable.
- `ifid_w_en`  out  1  `if_id` write enable.
- `ifid_flush`  out  1  `if_id` captures NOP.
- `idex_w_en`  out  1  `id_ex` write enable.
- `idex_bubble`  out  1  drives `id_ex` `flush_in`: the instruction captured into EX is a NOP.
- `halted`  out  1  pipeline fully drained after HALT.
- `err`  out  1  protocol violation, registered.

## Operation
- Scoreboard slots s0 (EX), s1 (MEM), s2 (WB). Each slot holds {v, reg[2:0], ld}.
- Every cycle while out of reset: s2<=s1, s1<=s0.
  - s0 <= {1, id_reg_to_write, id_MemRead} only when all hold: `id_valid`, `id_wreg_flag`, no stall, no redirect, state RUN.
  - Otherwise s0 <= invalid.
- Source match: for src k, `id_Readk` && slot.v && slot.reg==`id_R_regk`. Index r0 is an ordinary register, with no special case.
- Stall condition:
  - FORWARD=1: match against s0 with s0.ld.
  - FORWARD=0: match against any of s0, s1, s2. The register file has no write-through.
- Stall response: `pc_w_en`=0, `ifid_w_en`=0, `idex_bubble`=1, `idex_w_en`=1.
- Redirect: `ifid_flush`=1 and `idex_bubble`=1. PC and IF/ID enables stay 1 so the new target loads.
- Redirect has priority over stall and over halt acceptance.
- FSM states RUN, DRAIN, HALTED:
  - RUN→DRAIN when `id_valid`&&`id_halt`, no stall, no redirect. The HALT instruction itself enters EX normally.
  - DRAIN: `pc_w_en`=`ifid_w_en`=0, `idex_bubble`=1. DRAIN→HALTED when s0, s1, s2 are all invalid.
  - HALTED: all enables 0, `idex_bubble`=1, `halted`=1. HALTED is left only by reset.
- `err`: set for one cycle after `ex_redirect` is sampled in DRAIN or HALTED; redirect is still honoured in the FSM's outputs only in RUN.

## Timing
- All stall and redirect outputs are combinational from current state plus same-cycle ID/EX inputs. Scoreboard, FSM and `err` are registered.
- Reset values: state RUN; all slots invalid; `err`=0; `halted`=0. With `id_valid`=0 after reset: `pc_w_en`=`ifid_w_en`=`idex_w_en`=1, `ifid_flush`=`idex_bubble`=0.
- Load-use (FORWARD=1): exactly 1 bubble.
- Dependent back-to-back ALU ops (FORWARD=0): 3 bubbles. Distance 2: 2 bubbles. Distance 3: 1 bubble. Distance 4: none.
- Redirect: 1 cycle, squashing the two younger instructions (IF, ID).
- Simultaneous redirect and stall: redirect response only, and s0 is invalid.
- HALT drain: `halted` rises 3 cycles after the DRAIN transition when the pipeline is otherwise full.
- Reset mid-stall or mid-drain: the next cycle shows reset values.

## Structure
- The shared package holds:
  - FSM state encoding (2 bits: RUN=0, DRAIN=1, HALTED=2);
  - the slot struct/width constant;
  - register index width 3.
- One natural sub-module: `hz_scoreboard`, the 3-slot shift register plus match logic, parameterised by FORWARD. FSM and output muxing stay in `hazard_unit`.

## Test plan
- Reset, idle (`id_valid`=0) → enables 1, `idex_bubble`=0, `halted`=0, `err`=0.
- FORWARD=1: LD r3 followed by ADD reading r3 → exactly one cycle with `pc_w_en`=0 and `idex_bubble`=1, then normal. A non-load writer of r3 → no stall.
- FORWARD=0: ADD r2; ADD reading r2 → 3 bubble cycles. With one independent instruction between them → 2 bubbles.
- `ex_redirect` in the same cycle as a load-use hazard → `ifid_flush`=1, `idex_bubble`=1, `pc_w_en`=1. The next cycle shows no stall from the squashed dependant.
- HALT after three writers → DRAIN with enables 0; `halted`=1 after 3 cycles. Then `ex_redirect` → `err` pulses 1 cycle and the state stays HALTED.
- `rst`=0 during DRAIN → RUN on the next edge, slots cleared, `halted`=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit: FSM encoding, scoreboard
// slot layout and the per-slot blocking rule.
package hazard_unit_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // One in-flight writer: valid, destination index, writer is a load.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // Source k of the ID instruction reads the register held in this slot.
  function automatic logic slot_hit(input slot_t s, input logic rd_en,
                                    input logic [REG_W-1:0] r);
    return rd_en && s.v && (s.rd == r);
  endfunction

  // Whether a matching writer in this slot forces the reader to wait.
  // With forwarding only a load sitting in EX blocks (its data is not
  // ready until MEM); without forwarding every writer up to WB blocks
  // because the register file does not write through.
  function automatic logic slot_blocks(input slot_t s, input logic is_ex,
                                       input logic fwd);
    return !fwd || (is_ex && s.ld);
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Three-slot destination scoreboard (EX, MEM, WB) with source matching.
import hazard_unit_pkg::*;

module hz_scoreboard #(
  parameter int FORWARD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic             push_ld,
  input  logic             rd1_en,
  input  logic [REG_W-1:0] rd1,
  input  logic             rd2_en,
  input  logic [REG_W-1:0] rd2,
  output logic             hazard,
  output logic             empty
);

  localparam logic FWD = (FORWARD != 0);

  slot_t s_p0;  // writer now in EX
  slot_t s_p1;  // writer now in MEM
  slot_t s_p2;  // writer now in WB
  slot_t s_new;

  logic [2:0] blk;

  assign s_new = '{v: push, rd: push_rd, ld: push_ld};

  // Shift every cycle; reset only clears the valid bits.
  always_ff @(posedge clk) begin
    s_p2 <= s_p1;
    s_p1 <= s_p0;
    s_p0 <= s_new;
    if (!rst) begin
      s_p0.v <= 1'b0;
      s_p1.v <= 1'b0;
      s_p2.v <= 1'b0;
    end
  end

  // Per-slot hazard: either source matches and that writer still blocks.
  always_comb begin
    blk[0] = (slot_hit(s_p0, rd1_en, rd1) || slot_hit(s_p0, rd2_en, rd2))
             && slot_blocks(s_p0, 1'b1, FWD);
    blk[1] = (slot_hit(s_p1, rd1_en, rd1) || slot_hit(s_p1, rd2_en, rd2))
             && slot_blocks(s_p1, 1'b0, FWD);
    blk[2] = (slot_hit(s_p2, rd1_en, rd1) || slot_hit(s_p2, rd2_en, rd2))
             && slot_blocks(s_p2, 1'b0, FWD);
  end

  assign hazard = |blk;
  assign empty  = !(s_p0.v || s_p1.v || s_p2.v);

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage pipeline control: stall bubbles, redirect squash and
// HALT drain sequencing for the 16-bit five-stage core.
import hazard_unit_pkg::*;

module hazard_unit #(
  parameter int FORWARD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_Read1,
  input  logic             id_Read2,
  input  logic [REG_W-1:0] id_R_reg1,
  input  logic [REG_W-1:0] id_R_reg2,
  input  logic             id_wreg_flag,
  input  logic [REG_W-1:0] id_reg_to_write,
  input  logic             id_MemRead,
  input  logic             id_halt,
  input  logic             ex_redirect,
  output logic             pc_w_en,
  output logic             ifid_w_en,
  output logic             ifid_flush,
  output logic             idex_w_en,
  output logic             idex_bubble,
  output logic             halted,
  output logic             err
);

  state_t state;
  state_t state_nxt;

  logic hazard;
  logic sb_empty;
  logic in_run;
  logic stall;
  logic push;

  assign in_run = (state == ST_RUN);
  assign stall  = id_valid && hazard;
  // Only an instruction that really moves into EX occupies a slot; a
  // stalled or squashed one leaves a bubble behind.
  assign push   = in_run && id_valid && id_wreg_flag && !stall && !ex_redirect;

  hz_scoreboard #(
    .FORWARD (FORWARD)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_rd (id_reg_to_write),
    .push_ld (id_MemRead),
    .rd1_en  (id_Read1),
    .rd1     (id_R_reg1),
    .rd2_en  (id_Read2),
    .rd2     (id_R_reg2),
    .hazard  (hazard),
    .empty   (sb_empty)
  );

  // State register and registered protocol-error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= ex_redirect && !in_run;
    end
  end

  // Next state and pipeline enables; redirect beats stall beats HALT.
  always_comb begin
    state_nxt   = state;
    pc_w_en     = 1'b1;
    ifid_w_en   = 1'b1;
    ifid_flush  = 1'b0;
    idex_w_en   = 1'b1;
    idex_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (stall) begin
          pc_w_en     = 1'b0;
          ifid_w_en   = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid && id_halt) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pc_w_en     = 1'b0;
        ifid_w_en   = 1'b0;
        idex_bubble = 1'b1;
        if (sb_empty) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        pc_w_en     = 1'b0;
        ifid_w_en   = 1'b0;
        idex_w_en   = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign halted = (state == ST_HALTED);

endmodule
